// File: rtl/mo32_arb_if.sv
// Request/grant bundle between the five DMA engines and the result-mux arbiter.
// The master side is the engine cluster and the slave side is the arbiter.
interface mo32_arb_if;
  logic [4:0] req;
  logic [4:0] done;
  logic [4:0] gnt;
  logic       gnt_vld;
  logic [2:0] owner;
  logic       timeout_o;
  logic       busy;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_vld,
    input  owner,
    input  timeout_o,
    input  busy
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_vld,
    output owner,
    output timeout_o,
    output busy
  );
endinterface

// File: rtl/mo32_arb.sv
// Round-robin arbiter for the five-input result mux. A one-cycle dead gap separates owners,
// and a watchdog revokes any grant that is held too long.
module mo32_arb #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  mo32_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TMO_LAST_C = (TIMEOUT == 0) ? '0 : TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX_C  = '1;

  // Pick the first requester after last_v, ascending and wrapping at 4. A sole requester
  // wins against itself.
  function automatic logic [2:0] rr_pick(input logic [4:0] req_v, input logic [2:0] last_v);
    logic [2:0] idx_v;
    logic [2:0] pick_v;
    logic       found_v;
    idx_v   = last_v;
    pick_v  = last_v;
    found_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idx_v = (idx_v == 3'd4) ? 3'd0 : idx_v + 3'd1;
      if (!found_v && req_v[idx_v]) begin
        pick_v  = idx_v;
        found_v = 1'b1;
      end else begin
        found_v = found_v;
      end
    end
    return pick_v;
  endfunction

  function automatic logic [4:0] onehot(input logic [2:0] idx_v);
    return 5'd1 << idx_v;
  endfunction

  state_t               state_r, state_s;
  logic [4:0]           gnt_r, gnt_s;
  logic [2:0]           owner_r, owner_s, pick_s;
  logic [TIMEOUT_W-1:0] cnt_r, cnt_s;
  logic                 tmo_r, tmo_s;
  logic                 gnt_vld_r, busy_r;
  logic                 rel_s, exp_s;

  // Next state and next registered outputs. When done[owner] coincides with expiry, the
  // release counts as normal and timeout_o stays low.
  always_comb begin
    state_s = state_r;
    gnt_s   = 5'd0;
    owner_s = owner_r;
    cnt_s   = cnt_r;
    tmo_s   = 1'b0;
    pick_s  = rr_pick(bus.req, owner_r);
    rel_s   = bus.done[owner_r] | ~bus.req[owner_r];
    exp_s   = (TIMEOUT != 0) && (cnt_r == TMO_LAST_C);
    case (state_r)
      ST_IDLE, ST_GAP: begin
        if (|bus.req) begin
          state_s = ST_GRANT;
          owner_s = pick_s;
          gnt_s   = onehot(pick_s);
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (rel_s || exp_s) begin
          state_s = ST_GAP;
          tmo_s   = exp_s & ~rel_s;
        end else begin
          gnt_s = gnt_r;
          if (cnt_r == CNT_MAX_C) begin
            cnt_s = cnt_r;
          end else begin
            cnt_s = cnt_r + TIMEOUT_W'(1);
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_r   <= ST_IDLE;
      gnt_r     <= 5'd0;
      owner_r   <= 3'd4;
      cnt_r     <= '0;
      tmo_r     <= 1'b0;
      gnt_vld_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      gnt_r     <= gnt_s;
      owner_r   <= owner_s;
      cnt_r     <= cnt_s;
      tmo_r     <= tmo_s;
      gnt_vld_r <= |gnt_s;
      busy_r    <= (state_s != ST_IDLE);
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_vld   = gnt_vld_r;
  assign bus.owner     = owner_r;
  assign bus.timeout_o = tmo_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mo32_arb.sv
// Self-checking bench for mo32_arb: directed scenarios plus random traffic, all checked
// against a grant/hold/gap reference model.
module tb_mo32_arb;
  localparam int TMO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mo32_arb_if bus();

  mo32_arb #(.TIMEOUT_W(8), .TIMEOUT(TMO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: current holder (-1 = none), last holder, cycles held, and gap/timeout flags.
  int m_gnt, m_last, m_held;
  bit m_gap, m_tmo;

  task automatic model_reset();
    m_gnt  = -1;
    m_last = 4;
    m_held = 0;
    m_gap  = 1'b0;
    m_tmo  = 1'b0;
  endtask

  task automatic model_edge(input logic [4:0] r, input logic [4:0] d);
    bit rel, expire, found;
    int w;
    m_tmo = 1'b0;
    if (m_gnt >= 0) begin
      rel    = d[m_gnt] || !r[m_gnt];
      expire = (TMO > 0) && (m_held >= TMO);
      if (rel || expire) begin
        m_tmo = expire && !rel;
        m_gnt = -1;
        m_gap = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      m_gap = 1'b0;
      found = 1'b0;
      w     = 0;
      for (int k = 1; k <= 5; k++) begin
        if (!found && r[(m_last + k) % 5]) begin
          w     = (m_last + k) % 5;
          found = 1'b1;
        end
      end
      if (found) begin
        m_gnt  = w;
        m_last = w;
        m_held = 1;
      end
    end
  endtask

  function automatic logic [10:0] exp_vec();
    logic [4:0] g;
    g = 5'd0;
    if (m_gnt >= 0) g[m_gnt] = 1'b1;
    return {g, |g, 3'(m_last), m_tmo, (m_gnt >= 0) || m_gap};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {bus.gnt, bus.gnt_vld, bus.owner, bus.timeout_o, bus.busy};
  endfunction

  task automatic step(input logic [4:0] r, input logic [4:0] d);
    @(negedge clk);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    bus.req  = 5'd0;
    bus.done = 5'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    if (obs_vec() !== 11'b00000_0_100_0_0) begin
      n_fail++;
      $display("FAIL reset_values: got %b want %b", obs_vec(), 11'b00000_0_100_0_0);
    end
    n_cmp++;
  endtask

  task automatic test_reset_priority();
    do_reset();
    step(5'b10001, 5'd0);
    if (bus.gnt !== 5'b00001 || bus.owner !== 3'd0) begin
      n_fail++;
      $display("FAIL prio_first: got gnt %b owner %0d want 00001 owner 0", bus.gnt, bus.owner);
    end
    n_cmp++;
    step(5'b10001, 5'b00001);
    if (bus.gnt !== 5'b00000) begin
      n_fail++;
      $display("FAIL prio_gap: got gnt %b want 00000", bus.gnt);
    end
    n_cmp++;
    step(5'b10001, 5'd0);
    if (bus.gnt !== 5'b10000 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL prio_next: got %b want %b", obs_vec(), exp_vec());
    end
    n_cmp++;
  endtask

  task automatic test_rotation();
    int order [6] = '{0, 1, 2, 3, 4, 0};
    logic [4:0] dn;
    do_reset();
    for (int g = 0; g < 6; g++) begin
      step(5'b11111, 5'd0);
      if (bus.owner !== 3'(order[g]) || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rotation_owner[%0d]: got %b want owner %0d vec %b", g, obs_vec(), order[g], exp_vec());
      end
      n_cmp++;
      for (int c = 0; c < 2; c++) begin
        step(5'b11111, 5'd0);
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL rotation_hold[%0d]: got %b want %b", g, obs_vec(), exp_vec());
        end
        n_cmp++;
      end
      dn = 5'd0;
      dn[order[g]] = 1'b1;
      step(5'b11111, dn);
      if (bus.gnt !== 5'd0 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL rotation_gap[%0d]: got gnt %b busy %b want 00000 1", g, bus.gnt, bus.busy);
      end
      n_cmp++;
    end
  endtask

  task automatic test_watchdog();
    int hi, tmo_cnt;
    bit seen;
    hi = 0; tmo_cnt = 0; seen = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(5'b00100, 5'd0);
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL watchdog_cycle%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      n_cmp++;
      if (bus.timeout_o === 1'b1) begin
        tmo_cnt++;
        seen = 1'b1;
      end
      if (!seen && bus.gnt === 5'b00100) hi++;
    end
    if (hi != TMO || tmo_cnt != 1 || bus.gnt !== 5'b00100) begin
      n_fail++;
      $display("FAIL watchdog_len: got held %0d pulses %0d gnt %b want %0d 1 00100", hi, tmo_cnt, bus.gnt, TMO);
    end
    n_cmp++;
  endtask

  task automatic test_collision_noise();
    do_reset();
    for (int i = 0; i < TMO; i++) step(5'b00100, 5'd0);
    step(5'b00100, 5'b00100);
    if (bus.timeout_o !== 1'b0 || bus.gnt !== 5'd0 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL collision: got %b want %b", obs_vec(), exp_vec());
    end
    n_cmp++;
    do_reset();
    step(5'b00010, 5'd0);
    step(5'b00010, 5'b01000);
    if (bus.gnt !== 5'b00010 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL done_noise: got %b want %b", obs_vec(), exp_vec());
    end
    n_cmp++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(5'b01000, 5'd0);
    if (bus.gnt !== 5'b01000) begin
      n_fail++;
      $display("FAIL midrst_pre: got gnt %b want 01000", bus.gnt);
    end
    n_cmp++;
    #2;
    rst_n = 1'b0;
    #1;
    if (bus.gnt !== 5'd0 || bus.owner !== 3'd4 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got gnt %b owner %0d busy %b want 00000 4 0", bus.gnt, bus.owner, bus.busy);
    end
    n_cmp++;
    model_reset();
    @(negedge clk);
    bus.req = 5'd0;
    rst_n   = 1'b1;
    step(5'b00001, 5'd0);
    if (bus.gnt !== 5'b00001 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL midrst_regrant: got %b want %b", obs_vec(), exp_vec());
    end
    n_cmp++;
  endtask

  task automatic test_req_drop();
    do_reset();
    step(5'b00010, 5'd0);
    step(5'b00000, 5'd0);
    if (bus.gnt !== 5'd0 || bus.busy !== 1'b1 || bus.owner !== 3'd1) begin
      n_fail++;
      $display("FAIL drop_gap: got gnt %b busy %b owner %0d want 00000 1 1", bus.gnt, bus.busy, bus.owner);
    end
    n_cmp++;
    for (int i = 0; i < 3; i++) begin
      step(5'b00000, 5'd0);
      if (bus.gnt_vld !== 1'b0 || bus.busy !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL drop_idle%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      n_cmp++;
    end
  endtask

  task automatic test_random();
    logic [4:0] r, d, prev;
    r = 5'd0;
    prev = 5'd0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 5'($urandom);
      d = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
      step(r, d);
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cycle%0d: req %b done %b got %b want %b", i, r, d, obs_vec(), exp_vec());
      end
      n_cmp++;
      if ($countones(bus.gnt) > 1 || (prev != 5'd0 && bus.gnt != 5'd0 && bus.gnt != prev)) begin
        n_fail++;
        $display("FAIL random_onehot%0d: got gnt %b after %b want one-hot via gap", i, bus.gnt, prev);
      end
      n_cmp++;
      prev = bus.gnt;
    end
  endtask

  initial begin
    bus.req  = 5'd0;
    bus.done = 5'd0;
    model_reset();
    test_reset();
    test_reset_priority();
    test_rotation();
    test_watchdog();
    test_collision_noise();
    test_mid_reset();
    test_req_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
